shift_add_mult: RTL
===================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 Multiplicando  input  WIDTH  multiplicand; sampled with Start.
REQ-007 Multiplicador  input  WIDTH  multiplier; sampled with Start.
REQ-008 Product  output  2*WIDTH  result register; holds last result until the next result is written.
REQ-009 Busy  output  1  high while in RUN or FIX.
REQ-010 Done  output  1  registered one-cycle pulse, high in the cycle after the result is written to Product.

Function
REQ-011 FSM states are IDLE, RUN and FIX; reset state is IDLE.
REQ-012 IDLE with Start=1 at an edge: latch the operands, load the internal accumulator {WIDTH+1 zeros, multiplier}, load the cycle counter with WIDTH, and go to RUN.
REQ-013 Internal accumulator width is 2*WIDTH+1; the adder is internal, WIDTH+1 bits wide, and keeps the carry.
REQ-014 Each RUN edge performs one combined add-and-shift: if acc[0]=1, acc[2W:W] = acc[2W-1:W] + multiplicand; then the whole accumulator shifts right by 1 with a zero fill; the counter decrements by 1.
REQ-015 When the counter reaches 0 on a RUN edge, the transition is to FIX if a sign fix is needed, else to IDLE, writing acc[2W-1:0] to Product on that edge.
REQ-016 Latency in unsigned mode: Product is valid and Done=1 in the cycle following the (WIDTH+1)th edge after Start is sampled.
REQ-017 Start while Busy=1 is ignored; the operation in progress is unaffected.
REQ-018 Start=1 in the Done cycle, with the FSM in IDLE, is accepted (back-to-back operation).
REQ-019 Product changes only on the result-write edge or on Reset.
REQ-020 Done=1 lasts exactly one cycle per operation.

Reset
REQ-021 Reset=1 forces, immediately and independently of Clk: state IDLE, Product=0, Busy=0, Done=0, accumulator=0, counter=0.
REQ-022 Reset mid-operation abandons the operation with no Done pulse; the next Start after Reset deasserts behaves as from power-up.

Configuration
REQ-023 Macro SHIFT_ADD_MULT_SIGNED_EN compiles the signed mode in or out.
REQ-024 With the macro defined and Signed=1 at Start: load the magnitudes of both operands; record the result sign as the XOR of the operand MSBs; after RUN go to FIX.
REQ-025 In FIX, Product = the two's-complement negation of acc[2W-1:0] if the recorded sign is 1, else acc[2W-1:0], then go to IDLE; signed latency is WIDTH+2 edges.
REQ-026 The magnitude of the most negative operand, -2^(WIDTH-1), is 2^(WIDTH-1) and is handled correctly as an unsigned WIDTH-bit value.
REQ-027 With the macro undefined, the Signed port exists but is ignored: all operations are unsigned, FIX is unreachable, and the sign and negation logic is absent.

Verification
REQ-028 WIDTH=8, unsigned, 3*5 -> Product=16'd15, Done pulse after the 9th edge, Busy high for 8 cycles.
REQ-029 WIDTH=8, 255*255 -> Product=16'hFE01 (carry path exercised); 0*200 -> Product=0.
REQ-030 Signed build, WIDTH=8, Signed=1, -3*5 -> Product=16'hFFF1 after 10 edges; -128*-128 -> 16'h4000; -128*127 -> 16'hC080.
REQ-031 Start pulsed during RUN with different operands -> ignored, first result unchanged; Start held high through the Done cycle -> second operation starts, Done pulses twice.
REQ-032 Reset asserted mid-RUN (asynchronously, between edges) -> outputs 0 immediately, no Done; the next 7*9 operation -> Product=63.
REQ-033 Unsigned build with Signed=1 and 8'hFF*8'h02 -> Product=16'h01FE (unsigned result).

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier.
//
// A multiply is accepted from IDLE when Start is high. The multiplier sits in the low half of
// a 2*WIDTH+1 bit accumulator. Each RUN cycle conditionally adds the multiplicand into the
// upper half and shifts the whole accumulator right by one bit. After WIDTH RUN cycles the low
// 2*WIDTH bits hold the product.
//
// Build option: define SHIFT_ADD_MULT_SIGNED_EN to compile in two's-complement support. In a
// signed build, Signed=1 at Start multiplies the operand magnitudes. An extra FIX cycle then
// applies the result sign. Without the macro the Signed port is accepted but has no effect.
module shift_add_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    // Counter must hold the value WIDTH itself.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    localparam logic [1:0] StFix  = 2'd2;
`endif

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("shift_add_mult: WIDTH must be in 2..32");
    end

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;

    // Operand values actually loaded at Start (magnitudes in signed mode).
    logic [WIDTH-1:0]   load_mcand, load_mplier;

    // Datapath for one RUN step.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_add;
    logic [2*WIDTH:0]   acc_shift;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // fix_q: this operation ends with a FIX cycle; neg_q: the result must be negated.
    logic               fix_q, fix_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_low_neg;

    // Magnitude of a two's-complement operand. The most negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Select magnitudes only for signed requests.
    always_comb begin
        load_mcand  = Signed ? magnitude(Multiplicando) : Multiplicando;
        load_mplier = Signed ? magnitude(Multiplicador) : Multiplicador;
    end

    // Two's-complement negation of the raw magnitude product.
    always_comb begin
        acc_low_neg = ~acc_q[2*WIDTH-1:0] + (2*WIDTH)'(1);
    end
`else
    // Signed port has no effect in the unsigned-only build.
    logic unused_signed;
    assign unused_signed = Signed;

    // Operands load as-is.
    always_comb begin
        load_mcand  = Multiplicando;
        load_mplier = Multiplicador;
    end
`endif

    // One combined add-and-shift step; the adder keeps its carry in acc bit 2*WIDTH.
    always_comb begin
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        acc_add   = acc_q[0] ? {sum, acc_q[WIDTH-1:0]} : acc_q;
        acc_shift = {1'b0, acc_add[2*WIDTH:1]};
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        done_d    = 1'b0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        fix_d     = fix_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            StIdle: begin
                if (Start) begin
                    mcand_d = load_mcand;
                    acc_d   = {{(WIDTH + 1){1'b0}}, load_mplier};
                    cnt_d   = CW'(WIDTH);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                    fix_d   = Signed;
                    neg_d   = Signed & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_shift;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                    if (fix_q) begin
                        state_d = StFix;
                    end else begin
                        product_d = acc_shift[2*WIDTH-1:0];
                        done_d    = 1'b1;
                        state_d   = StIdle;
                    end
`else
                    product_d = acc_shift[2*WIDTH-1:0];
                    done_d    = 1'b1;
                    state_d   = StIdle;
`endif
                end
            end
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            StFix: begin
                product_d = neg_q ? acc_low_neg : acc_q[2*WIDTH-1:0];
                done_d    = 1'b1;
                state_d   = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // Sign bookkeeping registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fix_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            fix_q <= fix_d;
            neg_q <= neg_d;
        end
    end
`endif

    // Output drive.
    always_comb begin
        Product = product_q;
        Done    = done_q;
        Busy    = (state_q != StIdle);
    end

endmodule
